// File: rtl/sm_adder_pkg.sv
// Shared definitions for the ROM-based sign-magnitude adder.
//
// Contents:
//   SM_MIN_WIDTH / SM_MAX_WIDTH  supported operand widths (sign + magnitude)
//   SM_SIGN_W                    width of the sign field
//   sm_mag_width()               width of the magnitude field for a given operand width
//   sm_result_t                  result word sized for the widest supported operand
//   sm_entry()                   table-entry computation, evaluated only at elaboration
package sm_adder_pkg;

   localparam int SM_MIN_WIDTH = 2;
   localparam int SM_MAX_WIDTH = 6;
   localparam int SM_SIGN_W    = 1;

   typedef logic [SM_MAX_WIDTH:0] sm_result_t;

   function automatic int sm_mag_width(input int width);
      return width - SM_SIGN_W;
   endfunction

   // Result is {sign, magnitude}. The magnitude is width bits wide, so the
   // largest sum (2 * max magnitude) always fits. -0 inputs and zero results
   // are both folded to +0.
   function automatic sm_result_t sm_entry(input int width, input int a, input int b);
      int mag_mask;
      int sa;
      int sb;
      int ma;
      int mb;
      int mag;
      int sign;
      mag_mask = (1 << sm_mag_width(width)) - 1;
      ma = a & mag_mask;
      mb = b & mag_mask;
      sa = (a >> sm_mag_width(width)) & 1;
      sb = (b >> sm_mag_width(width)) & 1;
      if (ma == 0) sa = 0;
      if (mb == 0) sb = 0;
      if (sa == sb) begin
         mag  = ma + mb;
         sign = sa;
      end else if (ma >= mb) begin
         mag  = ma - mb;
         sign = sa;
      end else begin
         mag  = mb - ma;
         sign = sb;
      end
      if (mag == 0) sign = 0;
      return sm_result_t'((sign << width) | mag);
   endfunction

endpackage

// File: rtl/sm_add_rom.sv
// Constant lookup table holding every sign-magnitude sum, with a registered read.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, clears sum
//   addr  {a, b}, operand a in the upper half
//   sum   registered table entry {sign, magnitude}
module sm_add_rom
   import sm_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2*DATA_WIDTH-1:0]   addr,
   output logic [DATA_WIDTH:0]       sum
);

   localparam int RW    = DATA_WIDTH + 1;
   localparam int DEPTH = 1 << (2 * DATA_WIDTH);
   localparam int OPMASK = (1 << DATA_WIDTH) - 1;

   logic [DATA_WIDTH:0] rom [DEPTH];

   // Every entry is a constant expression, so the table folds to logic/ROM
   // with no adder in the datapath.
   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = RW'(sm_entry(DATA_WIDTH, (i >> DATA_WIDTH) & OPMASK, i & OPMASK));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
      end else begin
         sum <= rom[addr];
      end
   end

endmodule

// File: rtl/rom_based_sign_magnitude_adder.sv
// Sign-magnitude adder built from a precomputed lookup table.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   a, b  sign-magnitude operands (MSB = sign)
//   sum   registered sign-magnitude result, one bit wider than the operands
//
// Build option SM_ADDER_INPUT_REG_EN: registers a and b ahead of the table,
// latency 2 clk instead of 1. Results are identical in both builds.
module rom_based_sign_magnitude_adder
   import sm_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH:0]   sum
);

   logic [DATA_WIDTH-1:0] a_rom;
   logic [DATA_WIDTH-1:0] b_rom;

`ifdef SM_ADDER_INPUT_REG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rom <= '0;
         b_rom <= '0;
      end else begin
         a_rom <= a;
         b_rom <= b;
      end
   end
`else
   assign a_rom = a;
   assign b_rom = b;
`endif

   sm_add_rom #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rom (
      .clk  (clk),
      .rst  (rst),
      .addr ({a_rom, b_rom}),
      .sum  (sum)
   );

endmodule

// File: tb/tb_rom_based_sign_magnitude_adder.sv
module tb_rom_based_sign_magnitude_adder;

   localparam int DW = 4;
`ifdef SM_ADDER_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk;
   logic          rst;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic [DW:0]   sum;

   int n_cmp;
   int n_err;

   rom_based_sign_magnitude_adder #(
      .DATA_WIDTH (DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .sum (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Reference: convert to signed integers, add, re-encode.
   function automatic logic [DW:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y);
      int vx;
      int vy;
      int s;
      logic [DW:0] r;
      vx = int'(x[DW-2:0]);
      vy = int'(y[DW-2:0]);
      if (x[DW-1]) vx = -vx;
      if (y[DW-1]) vy = -vy;
      s = vx + vy;
      if (s < 0) r = {1'b1, DW'(-s)};
      else       r = {1'b0, DW'(s)};
      return r;
   endfunction

   task automatic apply(input string tag, input logic [DW-1:0] va, input logic [DW-1:0] vb,
                        input logic [DW:0] exp);
      a = va;
      b = vb;
      repeat (LAT) @(posedge clk);
      #1;
      chk(tag, sum, exp);
   endtask

   logic [DW:0] exp_q [256];

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      a = 4'b0111;
      b = 4'b0111;
      #2;
      chk("reset_async", sum, 5'b00000);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_held", sum, 5'b00000);
      rst = 1'b0;
      repeat (LAT) @(posedge clk);
      #1;
      chk("first_after_reset", sum, 5'b01110);

      apply("p4_p1", 4'b0100, 4'b0001, 5'b00101);
      apply("p4_m1", 4'b0100, 4'b1001, 5'b00011);
      apply("m4_p1", 4'b1100, 4'b0001, 5'b10011);
      apply("m4_m1", 4'b1100, 4'b1001, 5'b10101);
      apply("p7_p7", 4'b0111, 4'b0111, 5'b01110);
      apply("m7_m7", 4'b1111, 4'b1111, 5'b11110);
      apply("p3_m3", 4'b0011, 4'b1011, 5'b00000);
      apply("m0_m0", 4'b1000, 4'b1000, 5'b00000);
      apply("m1_p6", 4'b1001, 4'b0110, 5'b00101);
      apply("m0_m5", 4'b1000, 4'b1101, 5'b10101);
      apply("p2_m7", 4'b0010, 4'b1111, 5'b10101);

      // Hold stability: inputs unchanged, output must not move.
      @(posedge clk);
      #1;
      chk("hold", sum, 5'b10101);

      // Mid-stream reset with a result already present.
      apply("pre_reset", 4'b1111, 4'b1111, 5'b11110);
      a = 4'b0100;
      b = 4'b0001;
      #2;
      rst = 1'b1;
      #1;
      chk("reset_mid_async", sum, 5'b00000);
      @(posedge clk);
      #1;
      chk("reset_mid_held", sum, 5'b00000);
      rst = 1'b0;
      repeat (LAT) @(posedge clk);
      #1;
      chk("after_reset_mid", sum, 5'b00101);

      // Pipelined exhaustive sweep, one new pair every cycle.
      for (int k = 0; k < 256 + LAT; k++) begin
         @(posedge clk);
         #1;
         if (k >= LAT) chk($sformatf("sweep_%02x", k - LAT), sum, exp_q[k - LAT]);
         if (k < 256) begin
            a = DW'(k >> DW);
            b = DW'(k);
            exp_q[k] = model(a, b);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
